// File: rtl/if_fetch.sv
// Instruction fetch: PC, word-addressed imem, bubble/flush generation, halt detect; fetch is combinational from pc (0-cycle).
// c_PCWrite=0 stalls PC and IF/ID; redirects taken only when not stalled; halt word parks the stage until a redirect.
module if_fetch #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_PCWrite,
  input  logic        c_branch_taken,
  input  logic [31:0] branch_target,
  input  logic        c_jump,
  input  logic [31:0] jump_target,
  input  logic        imem_we,
  input  logic [9:0]  imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] instru_out,
  output logic [5:0]  ctr_out,
  output logic [5:0]  funcode_out,
  output logic [31:0] nextpc_out,
  output logic        c_IFIDWrite,
  output logic        c_if_flush,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] fetch_count
);
  localparam int          AW      = $clog2(IMEM_DEPTH);
  localparam logic [31:0] BUBBLE  = 32'hFC000000;
  localparam logic [31:0] HALT_WD = 32'hFFFFFFFF;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic [31:0] r_imem [IMEM_DEPTH];

  logic        w_in_range;
  logic [31:0] w_word;
  logic [31:0] w_pc_plus4;
  logic        w_redirect;
  logic        w_take;
  logic [31:0] w_target;
  logic        w_halt_now;
  logic        w_bubble;
  logic        w_flush;
  logic        w_deliver;
  logic        w_unused;

  // Program-load port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (imem_we) r_imem[imem_waddr[AW-1:0]] <= imem_wdata;
  end

  assign w_in_range = (r_pc[31:AW+2] == '0);
  assign w_word     = w_in_range ? r_imem[r_pc[AW+1:2]] : BUBBLE;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = c_branch_taken | c_jump;
  assign w_take     = w_redirect & c_PCWrite;
  assign w_target   = c_branch_taken ? {branch_target[31:2], 2'b00}
                                     : {jump_target[31:2], 2'b00};
  // A pending redirect outranks a halt word: the halt may be on the wrong path.
  assign w_halt_now = (r_state == S_RUN) & ~w_redirect & (w_word == HALT_WD);
  assign w_bubble   = (r_state != S_RUN) | w_halt_now;
  assign w_flush    = w_bubble | ((r_state == S_RUN) & w_take);
  assign w_deliver  = (r_state == S_RUN) & c_PCWrite & ~w_flush & w_in_range;
  assign w_unused   = |{imem_waddr >> AW, branch_target[1:0], jump_target[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_RUN;
        S_RUN: begin
          if (w_take)                       r_pc    <= w_target;
          else if (w_halt_now)              r_state <= S_HALT;
          else if (!w_redirect && c_PCWrite) r_pc   <= w_pc_plus4;
          if (w_deliver) r_fetch_count <= r_fetch_count + 32'd1;
        end
        S_HALT: begin
          if (w_take) begin
            r_pc    <= w_target;
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign instru_out  = w_bubble ? BUBBLE : w_word;
  assign ctr_out     = instru_out[31:26];
  assign funcode_out = instru_out[5:0];
  assign nextpc_out  = w_bubble ? 32'h0 : w_pc_plus4;
  assign c_IFIDWrite = c_PCWrite;
  assign c_if_flush  = w_flush;
  assign pc          = r_pc;
  assign halted      = (r_state == S_HALT);
  assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_if_fetch.sv
// Directed table-driven bench for if_fetch plus hand sequences for async reset corners.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_PCWrite = 1'b1;
  logic        c_branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        c_jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_we = 1'b0;
  logic [9:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [31:0] instru_out, nextpc_out, pc, fetch_count;
  logic [5:0]  ctr_out, funcode_out;
  logic        c_IFIDWrite, c_if_flush, halted;

  if_fetch #(.IMEM_DEPTH(64), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .c_PCWrite(c_PCWrite),
    .c_branch_taken(c_branch_taken), .branch_target(branch_target),
    .c_jump(c_jump), .jump_target(jump_target),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .instru_out(instru_out), .ctr_out(ctr_out), .funcode_out(funcode_out),
    .nextpc_out(nextpc_out), .c_IFIDWrite(c_IFIDWrite), .c_if_flush(c_if_flush),
    .pc(pc), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] BUB = 32'hFC000000;

  typedef struct packed {
    logic        pw;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] epc;
    logic [31:0] ins;
    logic [31:0] np;
    logic        fl;
    logic        hl;
    logic [31:0] fc;
    logic        ci;
    logic        cn;
  } vec_t;

  int n_checks = 0;
  int n_err = 0;
  vec_t tbl[20];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pw, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt, input logic [31:0] epc,
                              input logic [31:0] ins, input logic [31:0] np, input logic fl,
                              input logic hl, input logic [31:0] fc, input logic ci, input logic cn);
    vec_t v;
    v = '{pw, br, bt, jp, jt, epc, ins, np, fl, hl, fc, ci, cn};
    return v;
  endfunction

  task automatic load(input int a, input logic [31:0] d);
    @(negedge clk);
    imem_we = 1'b1; imem_waddr = 10'(a); imem_wdata = d;
    @(posedge clk); #1;
    imem_we = 1'b0;
  endtask

  task automatic set_in(input logic pw, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt);
    c_PCWrite = pw; c_branch_taken = br; branch_target = bt; c_jump = jp; jump_target = jt;
  endtask

  initial begin
    logic [31:0] w;
    // Program: words 0,1 from the boot test, halt at word 5, filler elsewhere.
    for (int i = 0; i < 34; i++) begin
      w = 32'h10000000 + 32'(i);
      if (i == 0) w = 32'h20080005;
      if (i == 1) w = 32'h00000020;
      if (i == 5) w = 32'hFFFFFFFF;
      load(i, w);
    end

    @(negedge clk); #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instru_out, BUB);
    check("rst_ctr", 32'(ctr_out), 32'h3F);
    check("rst_funct", 32'(funcode_out), 32'h0);
    check("rst_nextpc", nextpc_out, 32'h0);
    check("rst_flush", 32'(c_if_flush), 32'h1);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fc", fetch_count, 32'h0);

    //          pw br bt      jp jt        pc       instr          np        fl hl fc  ci cn
    tbl[0]  = mk(1, 0, 0,      0, 0,       32'h0,   BUB,           32'h0,    1, 0, 0, 1, 1);
    tbl[1]  = mk(1, 0, 0,      0, 0,       32'h0,   32'h20080005,  32'h4,    0, 0, 0, 1, 1);
    tbl[2]  = mk(1, 0, 0,      0, 0,       32'h4,   32'h00000020,  32'h8,    0, 0, 1, 1, 1);
    tbl[3]  = mk(0, 0, 0,      0, 0,       32'h8,   32'h10000002,  32'hC,    0, 0, 2, 1, 1);
    tbl[4]  = mk(0, 0, 0,      0, 0,       32'h8,   32'h10000002,  32'hC,    0, 0, 2, 1, 1);
    tbl[5]  = mk(0, 0, 0,      0, 0,       32'h8,   32'h10000002,  32'hC,    0, 0, 2, 1, 1);
    tbl[6]  = mk(1, 0, 0,      0, 0,       32'h8,   32'h10000002,  32'hC,    0, 0, 2, 1, 1);
    tbl[7]  = mk(1, 1, 32'h40, 1, 32'h80,  32'hC,   32'h10000003,  32'h10,   1, 0, 3, 0, 0);
    tbl[8]  = mk(0, 1, 32'h40, 1, 32'h80,  32'h40,  32'h10000010,  32'h44,   0, 0, 3, 1, 1);
    tbl[9]  = mk(1, 0, 0,      0, 0,       32'h40,  32'h10000010,  32'h44,   0, 0, 3, 1, 1);
    tbl[10] = mk(1, 0, 0,      1, 32'h13,  32'h44,  32'h10000011,  32'h48,   1, 0, 4, 0, 0);
    tbl[11] = mk(1, 0, 0,      0, 0,       32'h10,  32'h10000004,  32'h14,   0, 0, 4, 1, 1);
    tbl[12] = mk(1, 0, 0,      0, 0,       32'h14,  BUB,           32'h0,    1, 0, 5, 1, 1);
    tbl[13] = mk(1, 0, 0,      0, 0,       32'h14,  BUB,           32'h0,    1, 1, 5, 1, 1);
    tbl[14] = mk(0, 1, 32'h10, 0, 0,       32'h14,  BUB,           32'h0,    1, 1, 5, 1, 1);
    tbl[15] = mk(1, 1, 32'h10, 0, 0,       32'h14,  BUB,           32'h0,    1, 1, 5, 1, 1);
    tbl[16] = mk(1, 0, 0,      0, 0,       32'h10,  32'h10000004,  32'h14,   0, 0, 5, 1, 1);
    tbl[17] = mk(1, 0, 0,      1, 32'h100, 32'h14,  BUB,           32'h0,    1, 0, 6, 0, 0);
    tbl[18] = mk(1, 0, 0,      0, 0,       32'h100, BUB,           32'h104,  0, 0, 6, 1, 0);
    tbl[19] = mk(1, 0, 0,      0, 0,       32'h104, BUB,           32'h108,  0, 0, 6, 1, 0);

    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_in(tbl[i].pw, tbl[i].br, tbl[i].bt, tbl[i].jp, tbl[i].jt);
      #1;
      check($sformatf("pc[%0d]", i), pc, tbl[i].epc);
      check($sformatf("flush[%0d]", i), 32'(c_if_flush), 32'(tbl[i].fl));
      check($sformatf("ifidwr[%0d]", i), 32'(c_IFIDWrite), 32'(tbl[i].pw));
      check($sformatf("halted[%0d]", i), 32'(halted), 32'(tbl[i].hl));
      check($sformatf("fcount[%0d]", i), fetch_count, tbl[i].fc);
      if (tbl[i].ci) begin
        check($sformatf("instr[%0d]", i), instru_out, tbl[i].ins);
        check($sformatf("ctr[%0d]", i), 32'(ctr_out), 32'(tbl[i].ins[31:26]));
        check($sformatf("funct[%0d]", i), 32'(funcode_out), 32'(tbl[i].ins[5:0]));
      end
      if (tbl[i].cn) check($sformatf("nextpc[%0d]", i), nextpc_out, tbl[i].np);
    end

    // Async reset in the middle of a redirect: target must be discarded.
    @(negedge clk);
    set_in(1, 1, 32'h40, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_redir_pc", pc, 32'h0);
    check("arst_redir_fc", fetch_count, 32'h0);
    check("arst_redir_instr", instru_out, BUB);
    check("arst_redir_flush", 32'(c_if_flush), 32'h1);
    set_in(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("arst_redir_hold", pc, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("reboot_flush", 32'(c_if_flush), 32'h1);
    check("reboot_instr", instru_out, BUB);
    @(negedge clk); #1;
    check("reboot_fetch", instru_out, 32'h20080005);
    check("reboot_flush0", 32'(c_if_flush), 32'h0);

    // Walk into HALT again, then reset from HALT.
    set_in(1, 0, 0, 1, 32'h10);
    @(negedge clk);
    set_in(1, 0, 0, 0, 0);
    #1;
    check("h_pc10", pc, 32'h10);
    @(negedge clk); #1;
    check("h_pc14", pc, 32'h14);
    check("h_bubble", instru_out, BUB);
    check("h_notyet", 32'(halted), 32'h0);
    @(negedge clk); #1;
    check("h_halted", 32'(halted), 32'h1);
    check("h_fc", fetch_count, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_halt_pc", pc, 32'h0);
    check("arst_halt_halted", 32'(halted), 32'h0);
    check("arst_halt_fc", fetch_count, 32'h0);
    check("arst_halt_instr", instru_out, BUB);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("reboot2_flush", 32'(c_if_flush), 32'h1);
    @(negedge clk); #1;
    check("reboot2_fetch", instru_out, 32'h20080005);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
